// File: rtl/countdown_timer_if.sv
// Control and display bundle for the BCD countdown timer.
// The master side drives load/preset/start/pause and observes the digits and flags.
// The slave side is the timer itself.
interface countdown_timer_if;
   logic       i_Load;
   logic [3:0] i_Preset0;
   logic [3:0] i_Preset1;
   logic [3:0] i_Preset2;
   logic       i_Start;
   logic       i_Pause;
   logic [3:0] o_Digit0;
   logic [3:0] o_Digit1;
   logic [3:0] o_Digit2;
   logic       o_Running;
   logic       o_Expired;
   logic       o_Done;

   modport master (
      output i_Load, i_Preset0, i_Preset1, i_Preset2, i_Start, i_Pause,
      input  o_Digit0, o_Digit1, o_Digit2, o_Running, o_Expired, o_Done
   );

   modport slave (
      input  i_Load, i_Preset0, i_Preset1, i_Preset2, i_Start, i_Pause,
      output o_Digit0, o_Digit1, o_Digit2, o_Running, o_Expired, o_Done
   );
endinterface

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer with prescaled tick, pause/resume and expiry.
// Digit 0 is least significant. All outputs come straight from registers.
module countdown_timer #(
   parameter int CLK_HZ  = 100000000,
   parameter int TICK_HZ = 20,
   parameter int CNT_W   = 23
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   countdown_timer_if.slave   bus
);

   localparam logic [CNT_W-1:0] LST_CLK = CNT_W'(CLK_HZ / TICK_HZ - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       digit_reg [3];
   logic [3:0]       digit_next [3];
   logic [3:0]       digit_dec [3];
   logic [3:0]       preset_raw [3];
   logic [3:0]       preset_clamped [3];
   logic [3:0]       borrow;
   logic             done_reg, done_next;
   logic             running_reg, expired_reg;
   logic             tick;
   logic             value_zero;
   logic             dec_zero;

   assign preset_raw[0] = bus.i_Preset0;
   assign preset_raw[1] = bus.i_Preset1;
   assign preset_raw[2] = bus.i_Preset2;

   // Per digit: clamp out-of-range presets to 9, and build the decremented
   // value with a borrow that ripples through digits sitting at 0.
   assign borrow[0] = 1'b1;
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         assign preset_clamped[gi] = (preset_raw[gi] > 4'd9) ? 4'd9 : preset_raw[gi];
         assign borrow[gi+1]       = borrow[gi] & (digit_reg[gi] == 4'd0);
         assign digit_dec[gi]      = !borrow[gi]              ? digit_reg[gi] :
                                     (digit_reg[gi] == 4'd0)  ? 4'd9 :
                                                                digit_reg[gi] - 4'd1;
      end
   endgenerate

   assign tick       = (state_reg == ST_RUN) && (cnt_reg == LST_CLK);
   assign value_zero = (digit_reg[0] == 4'd0) && (digit_reg[1] == 4'd0) && (digit_reg[2] == 4'd0);
   assign dec_zero   = (digit_dec[0] == 4'd0) && (digit_dec[1] == 4'd0) && (digit_dec[2] == 4'd0);

   // Next-state logic: load beats everything, then a tick's decrement,
   // then pause, then start/resume.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         digit_next[i] = digit_reg[i];
      end

      if (bus.i_Load) begin
         for (int i = 0; i < 3; i++) begin
            digit_next[i] = preset_clamped[i];
         end
         cnt_next   = '0;
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               cnt_next = '0;
               if (bus.i_Start) begin
                  if (value_zero) begin
                     state_next = ST_EXPIRED;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (tick) begin
                  cnt_next = '0;
                  for (int i = 0; i < 3; i++) begin
                     digit_next[i] = digit_dec[i];
                  end
                  // Reaching zero takes precedence over a simultaneous pause.
                  if (dec_zero) begin
                     state_next = ST_EXPIRED;
                     done_next  = 1'b1;
                  end else if (bus.i_Pause) begin
                     state_next = ST_PAUSE;
                  end
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
                  if (bus.i_Pause) begin
                     state_next = ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               // Prescaler keeps its value so the partial tick is not lost.
               if (bus.i_Start && !bus.i_Pause) begin
                  state_next = ST_RUN;
               end
            end
            default: begin
               state_next = ST_EXPIRED;
            end
         endcase
      end
   end

   // State, prescaler, digits and status flags.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         for (int i = 0; i < 3; i++) begin
            digit_reg[i] <= 4'd0;
         end
         done_reg    <= 1'b0;
         running_reg <= 1'b0;
         expired_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         for (int i = 0; i < 3; i++) begin
            digit_reg[i] <= digit_next[i];
         end
         done_reg    <= done_next;
         running_reg <= (state_next == ST_RUN);
         expired_reg <= (state_next == ST_EXPIRED);
      end
   end

   assign bus.o_Digit0  = digit_reg[0];
   assign bus.o_Digit1  = digit_reg[1];
   assign bus.o_Digit2  = digit_reg[2];
   assign bus.o_Running = running_reg;
   assign bus.o_Expired = expired_reg;
   assign bus.o_Done    = done_reg;

endmodule
